// File: rtl/cru_sequencer.sv
// CRU controller for the TIPI card: synchronises the TI CRU bus, glitch-filters CRUCLK,
// commits single-bit writes to a 4-bit register, serves bit reads and times the Pi reset pulse.
module cru_sequencer #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned FILTER_CYCLES      = 3,
  parameter int unsigned RESET_PULSE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:3]  cru_base,
  input  logic        ti_cru_clk,
  input  logic        ti_memen,
  input  logic        ti_ph3,
  input  logic [0:14] addr,
  input  logic        ti_cru_out,
  output logic        ti_cru_in,
  output logic [0:3]  bits,
  output logic        pi_reset,
  output logic        busy
);

  localparam int unsigned FW = (FILTER_CYCLES + 1 > 2) ? $clog2(FILTER_CYCLES + 1) : 1;
  localparam int unsigned PW = (RESET_PULSE_CYCLES > 2) ? $clog2(RESET_PULSE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FILT, COMMIT, RELEASE} state_t;

  logic [SYNC_STAGES-1:0] r_cruclk_sync;
  logic [SYNC_STAGES-1:0] r_memen_sync;
  logic [SYNC_STAGES-1:0] r_cruout_sync;
  logic [0:14]            r_addr_sync [SYNC_STAGES];

  logic        w_cruclk_s;
  logic        w_memen_s;
  logic        w_cruout_s;
  logic [0:14] w_addr_s;
  logic        w_hit;
  logic [1:0]  w_idx;
  logic        w_unused;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [FW-1:0] r_fcnt;
  logic [FW-1:0] w_fcnt_nxt;
  logic        w_commit;

  logic [0:3]    r_bits;
  logic          r_busy;
  logic [PW-1:0] r_pcnt;
  logic          r_cru_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cruclk_sync <= '0;
      r_memen_sync  <= '0;
      r_cruout_sync <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_addr_sync[i] <= '0;
    end else begin
      r_cruclk_sync <= {r_cruclk_sync[SYNC_STAGES-2:0], ti_cru_clk};
      r_memen_sync  <= {r_memen_sync[SYNC_STAGES-2:0], ti_memen};
      r_cruout_sync <= {r_cruout_sync[SYNC_STAGES-2:0], ti_cru_out};
      r_addr_sync[0] <= addr;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_addr_sync[i] <= r_addr_sync[i-1];
    end
  end

  assign w_cruclk_s = r_cruclk_sync[SYNC_STAGES-1];
  assign w_memen_s  = r_memen_sync[SYNC_STAGES-1];
  assign w_cruout_s = r_cruout_sync[SYNC_STAGES-1];
  assign w_addr_s   = r_addr_sync[SYNC_STAGES-1];

  // addr_s[8:12] is deliberately not decoded, so the four bits alias across the window
  assign w_hit    = w_memen_s & (w_addr_s[0:3] == 4'b0001) & (w_addr_s[4:7] == cru_base);
  assign w_idx    = w_addr_s[13:14];
  assign w_unused = ^{ti_ph3, w_addr_s[8:12]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_cruclk_s) begin
          w_state_nxt = FILT;
          w_fcnt_nxt  = FW'(1);
        end
      end
      FILT: begin
        if (w_cruclk_s) begin
          w_state_nxt = IDLE;
        end else if (r_fcnt == FW'(FILTER_CYCLES)) begin
          w_state_nxt = COMMIT;
        end else begin
          w_fcnt_nxt = r_fcnt + 1'b1;
        end
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = RELEASE;
      end
      RELEASE: begin
        if (w_cruclk_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bits   <= '0;
      r_busy   <= 1'b0;
      r_pcnt   <= '0;
      r_cru_in <= 1'b0;
    end else begin
      r_cru_in <= w_hit ? r_bits[w_idx] : 1'b0;
      if (r_busy) begin
        if (r_pcnt == PW'(RESET_PULSE_CYCLES - 1)) begin
          r_busy    <= 1'b0;
          r_bits[1] <= 1'b0;
        end else begin
          r_pcnt <= r_pcnt + 1'b1;
        end
      end
      // bit 1 only arms the pulse from idle; while busy, writes to it are dropped
      if (w_commit && w_hit) begin
        if (w_idx == 2'd1) begin
          if (!r_busy && w_cruout_s) begin
            r_bits[1] <= 1'b1;
            r_busy    <= 1'b1;
            r_pcnt    <= '0;
          end
        end else begin
          r_bits[w_idx] <= w_cruout_s;
        end
      end
    end
  end

  assign bits      = r_bits;
  assign pi_reset  = r_busy;
  assign busy      = r_busy;
  assign ti_cru_in = r_cru_in;

endmodule
